// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: chunked two's-complement adder/subtractor.
// A WIDTH-bit add/sub is split into STAGES chunks of WIDTH/STAGES bits; each
// stage resolves one chunk and registers the carry into the next chunk.
// Valid/ready streaming on both sides; all stages advance together.
// Optional build macro PIPELINED_ADD_SUB_SAT_EN adds a per-transaction
// 'sat' input that clamps overflowing results to the signed limit.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPELINED_ADD_SUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
        end
    endgenerate

    // Per-stage state: valid, partial sum (chunks 0..k), carry into chunk k+1,
    // and the operands (b already inverted for subtract) for the upper chunks.
    logic             vld_q [STAGES];
    logic             cry_q [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic             ovf_q;

    logic             vld_n [STAGES];
    logic             cry_n [STAGES];
    logic [WIDTH-1:0] sum_n [STAGES];
    logic [WIDTH-1:0] a_n   [STAGES];
    logic [WIDTH-1:0] b_n   [STAGES];
    logic             ovf_n;
    logic             adv;

`ifdef PIPELINED_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic sat_q [STAGES];
    logic sat_n [STAGES];
`endif

    // Adds chunk k of x and y with carry c, merging it into the running sum acc.
    // Returns {carry_out_of_chunk, updated_sum}.
    function automatic logic [WIDTH:0] add_chunk(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] acc,
        input logic             c,
        input int unsigned      k
    );
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] r;
        part = {1'b0, x[k*CHUNK +: CHUNK]} + {1'b0, y[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c};
        r = acc;
        r[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        return {part[CHUNK], r};
    endfunction

    // Next-state of every stage plus overflow/saturation on the final chunk.
    always_comb begin
        logic [WIDTH:0] res;
        adv = !vld_q[STAGES-1] || out_ready;

        a_n[0]   = a;
        b_n[0]   = sub ? ~b : b;
        vld_n[0] = in_valid;
        res      = add_chunk(a, sub ? ~b : b, '0, sub ? ~cin : cin, 0);
        cry_n[0] = res[WIDTH];
        sum_n[0] = res[WIDTH-1:0];
`ifdef PIPELINED_ADD_SUB_SAT_EN
        sat_n[0] = sat;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_n[k]   = a_q[k-1];
            b_n[k]   = b_q[k-1];
            vld_n[k] = vld_q[k-1];
            res      = add_chunk(a_q[k-1], b_q[k-1], sum_q[k-1], cry_q[k-1], k);
            cry_n[k] = res[WIDTH];
            sum_n[k] = res[WIDTH-1:0];
`ifdef PIPELINED_ADD_SUB_SAT_EN
            sat_n[k] = sat_q[k-1];
`endif
        end

        // Same-sign operands with a differing result sign is exactly
        // carry-into-MSB XOR carry-out-of-MSB.
        ovf_n = (a_n[STAGES-1][WIDTH-1] == b_n[STAGES-1][WIDTH-1]) &&
                (sum_n[STAGES-1][WIDTH-1] != a_n[STAGES-1][WIDTH-1]);

`ifdef PIPELINED_ADD_SUB_SAT_EN
        // On overflow the true result has the sign of the operands.
        if (sat_n[STAGES-1] && ovf_n) begin
            sum_n[STAGES-1] = a_n[STAGES-1][WIDTH-1] ? SMIN : SMAX;
        end
`endif
    end

    // Pipeline registers: cleared by reset, shifted as a whole when adv=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '{default: 1'b0};
            cry_q <= '{default: 1'b0};
            sum_q <= '{default: '0};
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            ovf_q <= 1'b0;
`ifdef PIPELINED_ADD_SUB_SAT_EN
            sat_q <= '{default: 1'b0};
`endif
        end else if (adv) begin
            vld_q <= vld_n;
            cry_q <= cry_n;
            sum_q <= sum_n;
            a_q   <= a_n;
            b_q   <= b_n;
            ovf_q <= ovf_n;
`ifdef PIPELINED_ADD_SUB_SAT_EN
            sat_q <= sat_n;
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, STAGES=4) using a
// scoreboard queue filled on acceptance and drained on output transfer.
module tb_pipelined_add_sub;

    localparam int unsigned W  = 16;
    localparam int unsigned ST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
`ifdef PIPELINED_ADD_SUB_SAT_EN
    logic         sat;
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    pipelined_add_sub #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPELINED_ADD_SUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           n_out   = 0;
    logic         held    = 1'b0;
    logic [W-1:0] held_s;
    logic         held_c;
    logic         held_o;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference computed with integer arithmetic, independent of chunking.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb_i, input logic st);
        exp_t e;
        int   sa, sbv, ua, ub, r, u;
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        ua  = int'(av);
        ub  = int'(bv);
        r   = sb_i ? (sa - sbv - int'(ci)) : (sa + sbv + int'(ci));
        u   = sb_i ? (ua - ub - int'(ci)) : (ua + ub + int'(ci));
        e.o = (r > 32767) || (r < -32768);
        e.c = sb_i ? (ua >= ub + int'(ci)) : (u > 65535);
        e.s = u[W-1:0];
        if (SAT_ON && st && e.o) e.s = (r > 0) ? 16'h7FFF : 16'h8000;
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb_i, input logic st, input bit lat);
        exp_t e;
        a = av;
        b = bv;
        cin = ci;
        sub = sb_i;
`ifdef PIPELINED_ADD_SUB_SAT_EN
        sat = st;
`endif
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && rst_n === 1'b1) begin
                e = model(av, bv, ci, sb_i, st);
                e.acc = cyc;
                e.lat = lat;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard compare, stall stability, spurious outputs.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_s", s, held_s);
                check("hold_cout", cout, held_c);
                check("hold_ovf", ovf, held_o);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else if (out_valid && out_ready) begin
                mon_e = sb.pop_front();
                n_out <= n_out + 1;
                check("result_s", s, mon_e.s);
                check("result_cout", cout, mon_e.c);
                check("result_ovf", ovf, mon_e.o);
                if (mon_e.lat) check("latency", cyc - mon_e.acc, ST);
            end
            held   <= out_valid && !out_ready;
            held_s <= s;
            held_c <= cout;
            held_o <= ovf;
        end else begin
            held <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d outputs", n_out);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        // Reset held two cycles with a pending transaction on the inputs.
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0001;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b1;
`ifdef PIPELINED_ADD_SUB_SAT_EN
        sat = 1'b0;
`endif
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_s", s, 0);
            check("rst_cout", cout, 0);
            check("rst_ovf", ovf, 0);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;

        // Carry crossing the chunk 1 boundary, full ripple, subtract overflow.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
`ifdef PIPELINED_ADD_SUB_SAT_EN
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
`endif

        // Back-to-back stream with a 3-cycle stall after the 2nd result.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            begin
                k = 0;
                while (n_out < base + 2 && k < 200) begin
                    @(posedge clk);
                    k++;
                end
                check("stall_wait", n_out - base, 2);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out - base, 8);

        // Reset with three transactions in flight: none may emerge.
        base = n_out;
        for (int i = 0; i < 3; i++) send(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        send(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        check("midrst_count", n_out - base, 1);

        // Random traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
